mesh_router_xy: RTL and testbench

MESH_ROUTER_XY -- requirements
Module: mesh_router_xy

---
 rtl/mesh_router_xy.sv | 185 ++++++++++++++++++
 tb/tb_mesh_router_xy.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_router_xy.sv
// Five-port input-buffered XY mesh router: per-input FIFOs, XY routing, round-robin output
// arbitration, and registered outputs. Overflow and illegal-route drops are counted in drop_cnt.
module mesh_router_xy #(
    parameter int         DATA_W     = 32,
    parameter int         MESH_X     = 4,
    parameter int         MESH_Y     = 2,
    parameter int         X_POS      = 0,
    parameter int         Y_POS      = 0,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [4:0] PORT_EN    = 5'b11111
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5*DATA_W-1:0] in_data,
    input  logic [4:0]          in_valid,
    output logic [4:0]          in_full,
    output logic [5*DATA_W-1:0] out_data,
    output logic [4:0]          out_valid,
    input  logic [4:0]          out_full_in,
    output logic [15:0]         drop_cnt
);
    localparam int XW = (MESH_X > 1) ? $clog2(MESH_X) : 1;
    localparam int YW = (MESH_Y > 1) ? $clog2(MESH_Y) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XW:0]   MESH_X_L = (XW + 1)'(MESH_X);
    localparam logic [YW:0]   MESH_Y_L = (YW + 1)'(MESH_Y);
    localparam logic [XW-1:0] X_POS_L  = XW'(X_POS);
    localparam logic [YW-1:0] Y_POS_L  = YW'(Y_POS);

    logic [4:0][DATA_W-1:0] head;
    logic [4:0]             head_valid;
    logic [4:0]             illegal;
    logic [4:0]             ovf;
    logic [4:0]             pop;
    logic [4:0][4:0]        req_oh;     // [input][output]
    logic [4:0][4:0]        gnt_oh;     // [output][input]
    logic [3:0]             drop_sum;
    logic [15:0]            drop_cnt_reg, drop_cnt_next;

    genvar gi;

    // ---------------- input FIFOs and route computation ----------------
    for (gi = 0; gi < 5; gi++) begin : g_in
        if (PORT_EN[gi]) begin : g_fifo
            logic [DATA_W-1:0] mem [FIFO_DEPTH];
            logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
            logic [CW-1:0]     count_reg;
            logic [XW-1:0]     dst_x;
            logic [YW-1:0]     dst_y;
            logic [4:0]        route_oh;
            logic              wr_en;

            assign wr_en          = in_valid[gi] && (count_reg < CW'(FIFO_DEPTH));
            assign ovf[gi]        = in_valid[gi] && (count_reg == CW'(FIFO_DEPTH));
            // One spare slot absorbs the flit already in flight when upstream sees full.
            assign in_full[gi]    = (count_reg >= CW'(FIFO_DEPTH - 1));
            assign head_valid[gi] = (count_reg != '0);
            assign head[gi]       = mem[rd_ptr_reg];
            assign dst_x          = head[gi][XW-1:0];
            assign dst_y          = head[gi][XW+YW-1:XW];

            always_comb begin
                route_oh = 5'b00001;
                if (dst_x > X_POS_L)      route_oh = 5'b00010;
                else if (dst_x < X_POS_L) route_oh = 5'b00100;
                else if (dst_y > Y_POS_L) route_oh = 5'b10000;
                else if (dst_y < Y_POS_L) route_oh = 5'b01000;
            end

            assign illegal[gi] = head_valid[gi] &&
                                 (({1'b0, dst_x} >= MESH_X_L) ||
                                  ({1'b0, dst_y} >= MESH_Y_L) ||
                                  (|(route_oh & ~PORT_EN)));
            assign req_oh[gi]  = (head_valid[gi] && !illegal[gi]) ? route_oh : 5'b00000;

            always_ff @(posedge clk) begin
                if (wr_en) mem[wr_ptr_reg] <= in_data[gi*DATA_W +: DATA_W];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_en)    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    if (wr_en && !pop[gi])      count_reg <= count_reg + CW'(1);
                    else if (pop[gi] && !wr_en) count_reg <= count_reg - CW'(1);
                end
            end
        end else begin : g_off
            assign ovf[gi]        = 1'b0;
            assign in_full[gi]    = 1'b0;
            assign head_valid[gi] = 1'b0;
            assign head[gi]       = '0;
            assign illegal[gi]    = 1'b0;
            assign req_oh[gi]     = 5'b00000;
        end
    end

    // An input leaves its FIFO either by winning an output or by being discarded as illegal.
    always_comb begin
        pop = illegal;
        for (int o = 0; o < 5; o++) pop = pop | gnt_oh[o];
    end

    // ---------------- output arbiters and registers ----------------
    for (gi = 0; gi < 5; gi++) begin : g_out
        if (PORT_EN[gi]) begin : g_arb
            logic [2:0]        ptr_reg, ptr_next;
            logic [2:0]        grant_idx;
            logic              grant_found;
            logic [4:0]        req_col, gnt_vec;
            logic [3:0]        idx;
            logic [DATA_W-1:0] grant_data, out_data_reg;
            logic              out_valid_reg;

            always_comb begin
                req_col     = '0;
                gnt_vec     = '0;
                grant_found = 1'b0;
                grant_idx   = 3'd0;
                idx         = 4'd0;
                grant_data  = '0;
                for (int i = 0; i < 5; i++) req_col[i] = req_oh[i][gi];
                // Scan from the priority pointer, wrapping modulo 5.
                for (int k = 0; k < 5; k++) begin
                    idx = {1'b0, ptr_reg} + 4'(k);
                    if (idx >= 4'd5) idx = idx - 4'd5;
                    if (!grant_found && req_col[idx[2:0]] && !out_full_in[gi]) begin
                        grant_found = 1'b1;
                        grant_idx   = idx[2:0];
                    end
                end
                if (grant_found) gnt_vec[grant_idx] = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    if (gnt_vec[i]) grant_data = head[i];
                end
                ptr_next = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_reg       <= 3'd0;
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                end else begin
                    out_valid_reg <= grant_found;
                    if (grant_found) begin
                        ptr_reg      <= ptr_next;
                        out_data_reg <= grant_data;
                    end
                end
            end

            assign gnt_oh[gi]                    = gnt_vec;
            assign out_valid[gi]                 = out_valid_reg;
            assign out_data[gi*DATA_W +: DATA_W] = out_data_reg;
        end else begin : g_off
            assign gnt_oh[gi]                    = 5'b00000;
            assign out_valid[gi]                 = 1'b0;
            assign out_data[gi*DATA_W +: DATA_W] = '0;
        end
    end

    // ---------------- drop counter (up to 10 drops per cycle, saturating) ----------------
    always_comb begin
        drop_sum = 4'd0;
        for (int i = 0; i < 5; i++) begin
            drop_sum = drop_sum + 4'(ovf[i]) + 4'(illegal[i]);
        end
        if (({1'b0, drop_cnt_reg} + 17'(drop_sum)) > 17'h0FFFF) drop_cnt_next = 16'hFFFF;
        else                                                  drop_cnt_next = drop_cnt_reg + 16'(drop_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_reg <= 16'd0;
        else        drop_cnt_reg <= drop_cnt_next;
    end

    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_mesh_router_xy.sv
// Bench for mesh_router_xy at (1,0) in a 4x2 mesh: directed table, contention, random vs. queue model,
// reset, illegal-route and drop-counter saturation checks.
module tb_mesh_router_xy;
    localparam int MX = 4, MY = 2, XP = 1, YP = 0, DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [159:0] a_in_data = '0, b_in_data = '0;
    logic [4:0]   a_in_valid = '0, b_in_valid = '0;
    logic [4:0]   a_out_full_in = '0, b_out_full_in = '0;
    logic [4:0]   a_in_full, b_in_full, a_out_valid, b_out_valid;
    logic [159:0] a_out_data, b_out_data;
    logic [15:0]  a_drop_cnt, b_drop_cnt;

    mesh_router_xy #(.DATA_W(32), .MESH_X(MX), .MESH_Y(MY), .X_POS(XP), .Y_POS(YP),
                     .FIFO_DEPTH(DEPTH), .PORT_EN(5'b11111)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_full(a_in_full), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_full_in(a_out_full_in), .drop_cnt(a_drop_cnt));

    // West and North disabled.
    mesh_router_xy #(.DATA_W(32), .MESH_X(MX), .MESH_Y(MY), .X_POS(XP), .Y_POS(YP),
                     .FIFO_DEPTH(DEPTH), .PORT_EN(5'b10011)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_full(b_in_full), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_full_in(b_out_full_in), .drop_cnt(b_drop_cnt));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model: per-input queues, rotating priority ----------------
    logic [31:0] mq [5][$];
    int          m_rr [5];
    logic [4:0]  m_ov;
    logic [31:0] m_od [5];
    int          m_drop;

    function automatic int route_of(input logic [31:0] f);
        int x, y;
        x = int'(f[1:0]);
        y = int'(f[2]);
        if (x >= MX || y >= MY) return -1;
        if (x > XP) return 1;
        if (x < XP) return 2;
        if (y > YP) return 4;
        if (y < YP) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            mq[i].delete();
            m_rr[i] = 0;
            m_od[i] = '0;
        end
        m_ov   = '0;
        m_drop = 0;
    endtask

    task automatic model_step(input logic [4:0] v, input logic [159:0] d, input logic [4:0] f);
        int  pre [5];
        bit  took [5];
        int  drops;
        int  i;
        drops = 0;
        for (int p = 0; p < 5; p++) begin
            pre[p]  = mq[p].size();
            took[p] = 0;
            if (pre[p] > 0 && route_of(mq[p][0]) < 0) begin
                took[p] = 1;
                drops++;
            end
        end
        for (int o = 0; o < 5; o++) begin
            m_ov[o] = 1'b0;
            if (!f[o]) begin
                for (int k = 0; k < 5; k++) begin
                    i = (m_rr[o] + k) % 5;
                    if (!took[i] && pre[i] > 0 && route_of(mq[i][0]) == o) begin
                        m_ov[o] = 1'b1;
                        m_od[o] = mq[i][0];
                        took[i] = 1;
                        m_rr[o] = (i + 1) % 5;
                        break;
                    end
                end
            end
        end
        for (int p = 0; p < 5; p++) if (took[p]) void'(mq[p].pop_front());
        for (int p = 0; p < 5; p++) begin
            if (v[p]) begin
                if (pre[p] < DEPTH) mq[p].push_back(d[p*32 +: 32]);
                else                drops++;
            end
        end
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    endtask

    task automatic cmp(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [159:0] eod;
        logic [4:0]   efull;
        eod   = '0;
        efull = '0;
        for (int o = 0; o < 5; o++) begin
            eod[o*32 +: 32] = m_od[o];
            efull[o]        = (mq[o].size() >= DEPTH - 1);
        end
        cmp("out_valid", 160'(a_out_valid), 160'(m_ov));
        cmp("out_data", a_out_data, eod);
        cmp("in_full", 160'(a_in_full), 160'(efull));
        cmp("drop_cnt", 160'(a_drop_cnt), 160'(m_drop));
    endtask

    // Drive one cycle on DUT A, advance the model, then compare just after the edge.
    task automatic step(input logic [4:0] v, input logic [159:0] d, input logic [4:0] f);
        a_in_valid    = v;
        a_in_data     = d;
        a_out_full_in = f;
        model_step(v, d, f);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_in_valid = '0; a_in_data = '0; a_out_full_in = '0;
        b_in_valid = '0; b_in_data = '0; b_out_full_in = '0;
        #1;
        cmp("rst_a_out_valid", 160'(a_out_valid), 160'(0));
        cmp("rst_a_out_data", a_out_data, 160'(0));
        cmp("rst_a_in_full", 160'(a_in_full), 160'(0));
        cmp("rst_a_drop", 160'(a_drop_cnt), 160'(0));
        cmp("rst_b_out_valid", 160'(b_out_valid), 160'(0));
        cmp("rst_b_drop", 160'(b_drop_cnt), 160'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0]  v;
        logic [31:0] d;
        logic [4:0]  f;
        logic [4:0]  ov;
        logic [31:0] east;
        logic [4:0]  full;
        logic [15:0] drop;
    } vec_t;

    vec_t         tbl [13];
    int           srcs [3];
    int           seqn [3];
    int           acc;
    logic [31:0]  got [$];
    logic [31:0]  g;
    logic [4:0]   v;
    logic [159:0] d;
    logic [4:0]   f;

    initial begin
        // Local-port injections only; East (bit 1) is the routed output.
        tbl[0]  = '{5'b00001, 32'h1234_5607, 5'b00000, 5'b00000, 32'h0,          5'b00000, 16'd0};
        tbl[1]  = '{5'b00000, 32'h0,         5'b00000, 5'b00010, 32'h1234_5607, 5'b00000, 16'd0};
        tbl[2]  = '{5'b00000, 32'h0,         5'b00000, 5'b00000, 32'h1234_5607, 5'b00000, 16'd0};
        tbl[3]  = '{5'b00001, 32'hB000_0003, 5'b00010, 5'b00000, 32'h1234_5607, 5'b00000, 16'd0};
        tbl[4]  = '{5'b00001, 32'hB000_0103, 5'b00010, 5'b00000, 32'h1234_5607, 5'b00000, 16'd0};
        tbl[5]  = '{5'b00001, 32'hB000_0203, 5'b00010, 5'b00000, 32'h1234_5607, 5'b00001, 16'd0};
        tbl[6]  = '{5'b00001, 32'hB000_0303, 5'b00010, 5'b00000, 32'h1234_5607, 5'b00001, 16'd0};
        tbl[7]  = '{5'b00001, 32'hB000_0403, 5'b00010, 5'b00000, 32'h1234_5607, 5'b00001, 16'd1};
        tbl[8]  = '{5'b00000, 32'h0,         5'b00000, 5'b00010, 32'hB000_0003, 5'b00001, 16'd1};
        tbl[9]  = '{5'b00000, 32'h0,         5'b00000, 5'b00010, 32'hB000_0103, 5'b00000, 16'd1};
        tbl[10] = '{5'b00000, 32'h0,         5'b00000, 5'b00010, 32'hB000_0203, 5'b00000, 16'd1};
        tbl[11] = '{5'b00000, 32'h0,         5'b00000, 5'b00010, 32'hB000_0303, 5'b00000, 16'd1};
        tbl[12] = '{5'b00000, 32'h0,         5'b00000, 5'b00000, 32'hB000_0303, 5'b00000, 16'd1};

        #2;
        do_reset();

        // Single hop and backpressure table.
        for (int t = 0; t < 13; t++) begin
            step(tbl[t].v, {128'b0, tbl[t].d}, tbl[t].f);
            cmp($sformatf("tbl%0d_out_valid", t), 160'(a_out_valid), 160'(tbl[t].ov));
            cmp($sformatf("tbl%0d_east_data", t), 160'(a_out_data[63:32]), 160'(tbl[t].east));
            cmp($sformatf("tbl%0d_in_full", t), 160'(a_in_full), 160'(tbl[t].full));
            cmp($sformatf("tbl%0d_drop", t), 160'(a_drop_cnt), 160'(tbl[t].drop));
        end

        // Contention: Local, West, North all target (2,0); upstream honours in_full.
        do_reset();
        srcs = '{0, 2, 3};
        seqn = '{0, 0, 0};
        acc  = 0;
        got.delete();
        for (int c = 0; c < 26; c++) begin
            v = '0;
            d = '0;
            if (c < 6) begin
                for (int s = 0; s < 3; s++) begin
                    if (!a_in_full[srcs[s]]) begin
                        v[srcs[s]] = 1'b1;
                        d[srcs[s]*32 +: 32] = 32'hC000_0002 | (32'(srcs[s]) << 12) | (32'(seqn[s]) << 8);
                        seqn[s]++;
                        acc++;
                    end
                end
            end
            step(v, d, 5'b00000);
            if (a_out_valid[1]) got.push_back(a_out_data[63:32]);
        end
        cmp("contention_count", 160'(got.size()), 160'(acc));
        for (int n = 0; n < 6; n++) begin
            g = (n < got.size()) ? got[n] : 32'hFFFF_FFFF;
            cmp($sformatf("contention_src%0d", n), 160'(g[15:12]), 160'(srcs[n % 3]));
            cmp($sformatf("contention_seq%0d", n), 160'(g[11:8]), 160'(n / 3));
        end
        cmp("contention_no_drop", 160'(a_drop_cnt), 160'(0));

        // Random traffic against the model.
        for (int r = 0; r < 400; r++) begin
            v = 5'($urandom_range(0, 31));
            d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            for (int o = 0; o < 5; o++) f[o] = ($urandom_range(0, 3) == 0);
            step(v, d, f);
        end
        for (int r = 0; r < 12; r++) step(5'b00000, '0, 5'b00000);

        // Reset mid-operation with three flits buffered.
        step(5'b00001, {128'b0, 32'h7700_0003}, 5'b00000);
        step(5'b00000, '0, 5'b00000);
        for (int k = 0; k < 3; k++) step(5'b00001, {128'b0, 32'h8800_0003 | (32'(k) << 8)}, 5'b00010);
        cmp("pre_reset_in_full", 160'(a_in_full[0]), 160'(1));
        #2;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(5'b00000, '0, 5'b00000);
            cmp("stale_after_reset", 160'(a_out_valid), 160'(0));
        end

        // Disabled ports: South delivers to Local; Local->West is illegal and dropped.
        b_in_valid = 5'b11000;
        b_in_data  = '0;
        b_in_data[4*32 +: 32] = 32'hD000_0001;
        b_in_data[3*32 +: 32] = 32'hEEEE_0007;
        @(posedge clk); #1;
        cmp("b_in_full_c0", 160'(b_in_full), 160'(0));
        cmp("b_out_valid_c0", 160'(b_out_valid), 160'(0));
        b_in_valid = 5'b00000;
        @(posedge clk); #1;
        cmp("b_out_valid_c1", 160'(b_out_valid), 160'(5'b00001));
        cmp("b_local_data_c1", 160'(b_out_data[31:0]), 160'(32'hD000_0001));
        cmp("b_north_data_c1", 160'(b_out_data[127:96]), 160'(0));
        b_in_valid = 5'b00001;
        b_in_data  = {128'b0, 32'hD000_0100};
        @(posedge clk); #1;
        cmp("b_out_valid_c2", 160'(b_out_valid), 160'(0));
        cmp("b_drop_c2", 160'(b_drop_cnt), 160'(0));
        b_in_valid = 5'b01000;
        b_in_data  = '0;
        b_in_data[3*32 +: 32] = 32'hEEEE_0007;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            cmp("b_drop_illegal", 160'(b_drop_cnt), 160'(1));
            cmp("b_out_valid_idle", 160'(b_out_valid), 160'(0));
            cmp("b_north_in_full", 160'(b_in_full), 160'(0));
        end
        b_in_valid = 5'b00000;

        // Saturation: all five inputs flood East while East is blocked.
        d = {5{32'h5A00_0003}};
        for (int k = 0; k < 13200; k++) step(5'b11111, d, 5'b00010);
        cmp("drop_saturated", 160'(a_drop_cnt), 160'(16'hFFFF));
        for (int k = 0; k < 4; k++) step(5'b11111, d, 5'b00010);
        cmp("drop_sat_hold", 160'(a_drop_cnt), 160'(16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
